sr_pq_gen: RTL and testbench

Parametrised shift-register priority queue, successor to the fixed-size sr_pq. Holds up to DEPTH key/value entries sorted by key, with a selectable min-first or max-first ordering. Equal keys leave in insertion order (stable). Adds a configurable full policy (reject or evict-lowest), an occupancy count and drop/underflow status pulses. Drops into any pq_if-style consumer: head entry is always presented on kvo.

---
 rtl/pq_pkg.sv | 31 +++
 rtl/sr_pq_cell.sv | 77 +++++++
 rtl/sr_pq_gen.sv | 117 +++++++++++
 tb/tb_sr_pq_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types and key-ordering helper for the shift-register priority queues.
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef struct packed {
    logic valid;
    kv_t  kv;
  } cell_t;

  // Per-cycle action broadcast to every cell.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INS  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_REPL = 2'd3
  } pq_op_t;

  // Keys are zero-extended by the caller, so any key width up to 64 bits works.
  function automatic logic pq_beats(input logic [63:0] a, input logic [63:0] b,
                                    input logic min_first);
    return min_first ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/sr_pq_cell.sv
// One storage stage of the shift-register priority queue.
module sr_pq_cell
  import pq_pkg::*;
#(
  parameter int KEY_W     = KEY_WIDTH,
  parameter int VAL_W     = VAL_WIDTH,
  parameter bit MIN_FIRST = 1'b1,
  parameter bit HEAD      = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  pq_op_t                 op,
  input  logic [KEY_W+VAL_W-1:0] kvi,
  input  logic                   above_valid,
  input  logic [KEY_W+VAL_W-1:0] above_kv,
  input  logic                   above_nb,
  input  logic                   below_valid,
  input  logic [KEY_W+VAL_W-1:0] below_kv,
  input  logic                   below_nb,
  output logic                   valid,
  output logic [KEY_W+VAL_W-1:0] kv,
  output logic                   nb
);

  localparam int W = KEY_W + VAL_W;

  logic         valid_n;
  logic [W-1:0] kv_n;

  // nb: this entry stays ahead of kvi (the new key does not beat it).
  assign nb = valid && !pq_beats(64'(kvi[W-1 -: KEY_W]), 64'(kv[W-1 -: KEY_W]), MIN_FIRST);

  always_comb begin
    valid_n = valid;
    kv_n    = kv;
    case (op)
      OP_INS: begin
        if (!nb) begin
          if (above_nb) begin
            valid_n = 1'b1;
            kv_n    = kvi;
          end else begin
            valid_n = above_valid;
            kv_n    = above_kv;
          end
        end
      end
      OP_DEQ: begin
        valid_n = below_valid;
        kv_n    = below_kv;
      end
      // Head leaves and kvi enters: cells ahead of the insertion point move up,
      // the insertion point loads kvi, everything behind it stays put.
      OP_REPL: begin
        if (below_nb) begin
          valid_n = below_valid;
          kv_n    = below_kv;
        end else if (nb || HEAD) begin
          valid_n = 1'b1;
          kv_n    = kvi;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      kv    <= '0;
    end else begin
      valid <= valid_n;
      kv    <= kv_n;
    end
  end

endmodule

// File: rtl/sr_pq_gen.sv
// Parametrised stable shift-register priority queue with min/max ordering,
// reject/evict full policy, occupancy count and drop/underflow pulses.
module sr_pq_gen
  import pq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int KEY_W     = KEY_WIDTH,
  parameter int VAL_W     = VAL_WIDTH,
  parameter bit MIN_FIRST = 1'b1,
  parameter bit EVICT     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enq,
  input  logic                         deq,
  input  logic [KEY_W+VAL_W-1:0]       kvi,
  output logic [KEY_W+VAL_W-1:0]       kvo,
  output logic                         ovalid,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         dropped,
  output logic                         underflow
);

  localparam int W  = KEY_W + VAL_W;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Index 0 is a phantom cell above the head, DEPTH+1 a phantom below the tail.
  logic         cv  [DEPTH+2];
  logic [W-1:0] ckv [DEPTH+2];
  logic         cnb [DEPTH+2];

  pq_op_t        op;
  logic [CW-1:0] count_n;
  logic          drop_n;
  logic          uf_n;

  assign cv[0]        = 1'b0;
  assign ckv[0]       = '0;
  assign cnb[0]       = 1'b1;
  assign cv[DEPTH+1]  = 1'b0;
  assign ckv[DEPTH+1] = '0;
  assign cnb[DEPTH+1] = 1'b0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    sr_pq_cell #(
      .KEY_W    (KEY_W),
      .VAL_W    (VAL_W),
      .MIN_FIRST(MIN_FIRST),
      .HEAD     (i == 0)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .kvi        (kvi),
      .above_valid(cv[i]),
      .above_kv   (ckv[i]),
      .above_nb   (cnb[i]),
      .below_valid(cv[i+2]),
      .below_kv   (ckv[i+2]),
      .below_nb   (cnb[i+2]),
      .valid      (cv[i+1]),
      .kv         (ckv[i+1]),
      .nb         (cnb[i+1])
    );
  end

  assign kvo    = ckv[1];
  assign ovalid = cv[1];

  // Evict-when-full reuses the plain insert: a key that does not beat the tail
  // leaves every cell holding, otherwise the old tail shifts out.
  always_comb begin
    op      = OP_HOLD;
    count_n = count;
    drop_n  = 1'b0;
    uf_n    = 1'b0;
    if (enq && deq && !empty) begin
      op = OP_REPL;
    end else if (enq) begin
      uf_n = deq;
      if (!full) begin
        op      = OP_INS;
        count_n = count + 1'b1;
      end else begin
        drop_n = 1'b1;
        if (EVICT) op = OP_INS;
      end
    end else if (deq) begin
      if (empty) begin
        uf_n = 1'b1;
      end else begin
        op      = OP_DEQ;
        count_n = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      dropped   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_n;
      empty     <= (count_n == '0);
      full      <= (count_n == DEPTH_C);
      dropped   <= drop_n;
      underflow <= uf_n;
    end
  end

endmodule

// File: tb/tb_sr_pq_gen.sv
// Self-checking bench: three queue configurations against a sorted-array model.
module tb_sr_pq_gen;
  import pq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enq_s [3];
  logic        deq_s [3];
  logic [15:0] kvi_s [3];
  logic [15:0] kvo_s [3];
  logic        ov_s [3], em_s [3], fu_s [3], dr_s [3], uf_s [3];
  logic [2:0]  cnt0, cnt1;
  logic [1:0]  cnt2;
  logic [24:0] obs [3];

  sr_pq_gen #(.DEPTH(4), .MIN_FIRST(1'b1), .EVICT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .enq(enq_s[0]), .deq(deq_s[0]), .kvi(kvi_s[0]),
    .kvo(kvo_s[0]), .ovalid(ov_s[0]), .empty(em_s[0]), .full(fu_s[0]),
    .count(cnt0), .dropped(dr_s[0]), .underflow(uf_s[0]));

  sr_pq_gen #(.DEPTH(4), .MIN_FIRST(1'b1), .EVICT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .enq(enq_s[1]), .deq(deq_s[1]), .kvi(kvi_s[1]),
    .kvo(kvo_s[1]), .ovalid(ov_s[1]), .empty(em_s[1]), .full(fu_s[1]),
    .count(cnt1), .dropped(dr_s[1]), .underflow(uf_s[1]));

  sr_pq_gen #(.DEPTH(2), .MIN_FIRST(1'b0), .EVICT(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .enq(enq_s[2]), .deq(deq_s[2]), .kvi(kvi_s[2]),
    .kvo(kvo_s[2]), .ovalid(ov_s[2]), .empty(em_s[2]), .full(fu_s[2]),
    .count(cnt2), .dropped(dr_s[2]), .underflow(uf_s[2]));

  assign obs[0] = {kvo_s[0], ov_s[0], em_s[0], fu_s[0], 1'b0, cnt0, dr_s[0], uf_s[0]};
  assign obs[1] = {kvo_s[1], ov_s[1], em_s[1], fu_s[1], 1'b0, cnt1, dr_s[1], uf_s[1]};
  assign obs[2] = {kvo_s[2], ov_s[2], em_s[2], fu_s[2], 2'b00, cnt2, dr_s[2], uf_s[2]};

  localparam logic [24:0] RST_OBS = {16'h0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: each queue is a sorted array, head at index 0.
  int          mdepth [3] = '{4, 4, 2};
  bit          mminf  [3] = '{1'b1, 1'b1, 1'b0};
  bit          mevict [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] mdat [3][9];
  int          mcnt [3];
  bit          mdrop [3];
  bit          muf   [3];

  function automatic logic [15:0] mk(input int k, input int v);
    kv_t t;
    t.key = 8'(k);
    t.val = 8'(v);
    return t;
  endfunction

  task automatic m_reset();
    for (int u = 0; u < 3; u++) begin
      mcnt[u] = 0; mdrop[u] = 1'b0; muf[u] = 1'b0;
    end
  endtask

  task automatic m_insert(input int u, input logic [15:0] kv);
    int j;
    j = mcnt[u];
    for (int i = mcnt[u] - 1; i >= 0; i--)
      if (pq_beats(64'(kv[15:8]), 64'(mdat[u][i][15:8]), mminf[u])) j = i;
    for (int i = mcnt[u]; i > j; i--) mdat[u][i] = mdat[u][i-1];
    mdat[u][j] = kv;
    mcnt[u]++;
  endtask

  task automatic m_pop(input int u);
    for (int i = 0; i < mcnt[u] - 1; i++) mdat[u][i] = mdat[u][i+1];
    mcnt[u]--;
  endtask

  task automatic m_step(input int u);
    mdrop[u] = 1'b0;
    muf[u]   = 1'b0;
    if (!rst_n) begin
      mcnt[u] = 0;
    end else if (enq_s[u] && deq_s[u] && mcnt[u] > 0) begin
      m_pop(u);
      m_insert(u, kvi_s[u]);
    end else if (enq_s[u]) begin
      if (deq_s[u]) muf[u] = 1'b1;
      if (mcnt[u] < mdepth[u]) begin
        m_insert(u, kvi_s[u]);
      end else begin
        mdrop[u] = 1'b1;
        // Stable insert then dropping the last entry discards whichever loses.
        if (mevict[u]) begin
          m_insert(u, kvi_s[u]);
          mcnt[u]--;
        end
      end
    end else if (deq_s[u]) begin
      if (mcnt[u] == 0) muf[u] = 1'b1;
      else m_pop(u);
    end
  endtask

  function automatic logic [24:0] m_exp(input int u);
    logic [15:0] h;
    h = (mcnt[u] > 0) ? mdat[u][0] : 16'h0000;
    return {h, mcnt[u] != 0, mcnt[u] == 0, mcnt[u] == mdepth[u], 4'(mcnt[u]), mdrop[u], muf[u]};
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int u = 0; u < 3; u++) m_step(u);
    #1;
    for (int u = 0; u < 3; u++) check($sformatf("model_u%0d", u), obs[u], m_exp(u));
  endtask

  typedef struct {
    bit          enq;
    bit          deq;
    logic [15:0] kv;
    logic [15:0] e0;
    int          c0;
    bit          d0;
    logic [15:0] e1;
    int          c1;
    bit          d1;
    bit          uf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit e, input bit d, input logic [15:0] kv,
                     input logic [15:0] e0, input int c0, input bit d0,
                     input logic [15:0] e1, input int c1, input bit d1, input bit uf);
    vec_t r;
    r.enq = e; r.deq = d; r.kv = kv;
    r.e0 = e0; r.c0 = c0; r.d0 = d0;
    r.e1 = e1; r.c1 = c1; r.d1 = d1; r.uf = uf;
    tbl.push_back(r);
  endtask

  function automatic logic [24:0] pack(input logic [15:0] h, input int c, input bit d, input bit uf);
    return {h, c != 0, c == 0, c == 4, 4'(c), d, uf};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      enq_s[u] = 1'b0; deq_s[u] = 1'b0; kvi_s[u] = '0;
    end
    m_reset();
    tick();
    tick();
    for (int u = 0; u < 3; u++) check($sformatf("reset_u%0d", u), obs[u], RST_OBS);
    #2 rst_n = 1'b1;

    //  enq deq kvi        u0 head     cnt drop  u1 head     cnt drop  uf
    add(1, 0, mk(8,14),  mk(8,14),  1, 0,   mk(8,14),  1, 0,   0);
    add(1, 0, mk(14,14), mk(8,14),  2, 0,   mk(8,14),  2, 0,   0);
    add(1, 0, mk(9,10),  mk(8,14),  3, 0,   mk(8,14),  3, 0,   0);
    add(1, 0, mk(9,11),  mk(8,14),  4, 0,   mk(8,14),  4, 0,   0);
    add(1, 0, mk(9,12),  mk(8,14),  4, 1,   mk(8,14),  4, 1,   0);
    add(1, 0, mk(20,0),  mk(8,14),  4, 1,   mk(8,14),  4, 1,   0);
    add(0, 0, mk(0,0),   mk(8,14),  4, 0,   mk(8,14),  4, 0,   0);
    add(1, 1, mk(1,11),  mk(1,11),  4, 0,   mk(1,11),  4, 0,   0);
    add(0, 1, mk(0,0),   mk(9,10),  3, 0,   mk(9,10),  3, 0,   0);
    add(0, 1, mk(0,0),   mk(9,11),  2, 0,   mk(9,11),  2, 0,   0);
    add(0, 1, mk(0,0),   mk(14,14), 1, 0,   mk(9,12),  1, 0,   0);
    add(0, 1, mk(0,0),   mk(0,0),   0, 0,   mk(0,0),   0, 0,   0);
    add(0, 1, mk(0,0),   mk(0,0),   0, 0,   mk(0,0),   0, 0,   1);
    add(1, 1, mk(5,5),   mk(5,5),   1, 0,   mk(5,5),   1, 0,   1);
    add(0, 1, mk(0,0),   mk(0,0),   0, 0,   mk(0,0),   0, 0,   0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int u = 0; u < 2; u++) begin
        enq_s[u] = tbl[i].enq; deq_s[u] = tbl[i].deq; kvi_s[u] = tbl[i].kv;
      end
      tick();
      check($sformatf("vec%0d_u0", i), obs[0], pack(tbl[i].e0, tbl[i].c0, tbl[i].d0, tbl[i].uf));
      check($sformatf("vec%0d_u1", i), obs[1], pack(tbl[i].e1, tbl[i].c1, tbl[i].d1, tbl[i].uf));
    end
    for (int u = 0; u < 2; u++) begin
      enq_s[u] = 1'b0; deq_s[u] = 1'b0;
    end

    // Max-first, depth 2, then reset asserted while an enq to a full queue is pending.
    enq_s[2] = 1'b1; kvi_s[2] = mk(3,1);
    tick();
    kvi_s[2] = mk(7,2);
    tick();
    check("u2_max_head", 25'(kvo_s[2]), 25'(mk(7,2)));
    check("u2_full", 25'({fu_s[2], cnt2}), 25'({1'b1, 2'd2}));
    kvi_s[2] = mk(5,5);
    #3 rst_n = 1'b0;
    m_reset();
    #1;
    for (int u = 0; u < 3; u++) check($sformatf("async_reset_u%0d", u), obs[u], RST_OBS);
    tick();
    enq_s[2] = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("u2_no_pulse_after_reset", obs[2], RST_OBS);

    for (int n = 0; n < 600; n++) begin
      for (int u = 0; u < 3; u++) begin
        enq_s[u] = ($urandom_range(0, 99) < 55);
        deq_s[u] = ($urandom_range(0, 99) < 45);
        kvi_s[u] = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
